dilithium_shiftadd_mult: RTL and testbench
==========================================

Name: dilithium_shiftadd_mult

Overview:
Iterative radix-2 shift-add multiplier that forms the full product of two Dilithium coefficients, a*b. It sits directly upstream of the shift-add modular reduction stage. Its result_o drives the reduction's x input, and its valid/ready handshake gates the reduction's start pulse. It processes one operand bit per clock, trading latency for minimal area, which suits the precomputed shift-add datapath.

Parameters:
OP_LEN, 23, operand width in bits; equals the Dilithium modulus bit length (q = 8380417).
DATA_LENGTH, 64, output width; must be >= 2*OP_LEN; the product is zero-extended into it.

Ports:
clk_i  input  1  rising-edge clock.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  request a multiplication; sampled only in IDLE.
a_i  input  OP_LEN  operand a; captured on the accepting edge.
b_i  input  OP_LEN  operand b; captured on the accepting edge.
ready_i  input  1  downstream (reduction) can consume result_o.
busy_o  output  1  high whenever state != IDLE.
valid_o  output  1  result_o holds a finished product.
result_o  output  DATA_LENGTH  a*b, zero-extended; bits above 2*OP_LEN are always 0.

Behaviour:
- Reset: rst_i is sampled at the clock edge and overrides everything.
  - State goes to IDLE; the accumulator, shifted multiplicand, multiplier register and counter clear to 0.
  - busy_o=0, valid_o=0, result_o=0.
  - Reset mid-operation aborts the multiplication; no valid_o is produced for it.
- FSM has three states: IDLE, MUL, DONE.
- IDLE:
  - On an edge with start_i=1: load mcand <= a_i zero-extended to 2*OP_LEN, mplier <= b_i, acc <= 0, cnt <= 0; go to MUL.
  - With start_i=0: stay in IDLE.
- MUL, one step per edge:
  - If mplier[0]=1, acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - When cnt == OP_LEN-1 on this edge, go to DONE; acc then holds the full product.
- DONE:
  - valid_o=1 and result_o = acc. Both stay stable until the handshake.
  - On an edge with ready_i=1, go to IDLE; valid_o drops in the following cycle.
  - result_o retains the last product while in IDLE, until the next accept or reset.
- Latency:
  - Start accepted at edge t; MUL steps occur at edges t+1 .. t+OP_LEN.
  - valid_o is first high in the cycle after edge t+OP_LEN (23 cycles for the default).
  - Minimum issue interval is OP_LEN+2 cycles: accept, OP_LEN steps, one DONE cycle with ready_i=1.
- start_i is ignored in MUL and DONE.
  - A start coinciding with the DONE handshake edge is not accepted; it must be re-asserted in IDLE.
- Arithmetic:
  - acc is 2*OP_LEN bits wide; overflow is impossible because both operands are < 2^OP_LEN.
  - No modular reduction is performed here; that belongs to the downstream stage.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.
- busy_o is high in MUL and DONE.

Test Plan:
- Reset, then a_i=1, b_i=1, start_i pulse, ready_i=1 -> valid_o rises exactly 23 cycles after the accept edge; result_o=0x1; busy_o low one cycle after the handshake.
- a_i=b_i=8380416 (q-1) -> result_o=0x3FE004000000; a downstream reduction mod 8380417 yields 1.
- Zero-operand cases: a_i=0, b_i=12345 -> result_o=0. Then a_i=0x7FFFFF, b_i=0x7FFFFF -> result_o=0x3FFFFF000001.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o rises, and pulse start_i with new operands during that time -> valid_o and result_o hold unchanged, the pulse is ignored, and completion follows the handshake.
- Assert rst_i at MUL step 10 -> busy_o=0, valid_o=0, result_o=0 next cycle; no valid appears for the aborted op. A following start with 3*5 returns 15.
- Back-to-back ops 0x1234*0x56 then 0x7FFFFF*2 with ready_i tied to 1 -> results 0x61D78 and 0xFFFFFE; second accept no earlier than 25 cycles after the first.

Source files
------------

// File: rtl/dilithium_shiftadd_mult.sv
// Radix-2 shift-add multiplier for Dilithium coefficients: one multiplier bit per clock,
// full 2*OP_LEN-bit product presented with a valid/ready handshake toward the reduction stage.
module dilithium_shiftadd_mult #(
    parameter int OP_LEN      = 23,
    parameter int DATA_LENGTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [OP_LEN-1:0]      a_i,
    input  logic [OP_LEN-1:0]      b_i,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [DATA_LENGTH-1:0] result_o
);

    localparam int ACC_W = 2 * OP_LEN;
    localparam int CNT_W = (OP_LEN > 1) ? $clog2(OP_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [OP_LEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no branch leaves a signal unassigned (no latches).
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = MUL;
                    mcand_d  = ACC_W'(a_i);
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OP_LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // acc_q is the finished product and stays untouched until the next accept
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = DATA_LENGTH'(acc_q);

endmodule

// File: tb/tb_dilithium_shiftadd_mult.sv
// Self-checking bench for dilithium_shiftadd_mult: directed corner cases plus random
// operands compared against a plain a*b reference, with latency and handshake checks.
module tb_dilithium_shiftadd_mult;

    localparam int OP_LEN      = 23;
    localparam int DATA_LENGTH = 64;
    localparam int LATENCY     = OP_LEN;
    localparam int TIMEOUT     = 100;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   start_i = 1'b0;
    logic [OP_LEN-1:0]      a_i = '0;
    logic [OP_LEN-1:0]      b_i = '0;
    logic                   ready_i = 1'b0;
    logic                   busy_o;
    logic                   valid_o;
    logic [DATA_LENGTH-1:0] result_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int last_accept = 0;

    dilithium_shiftadd_mult #(
        .OP_LEN     (OP_LEN),
        .DATA_LENGTH(DATA_LENGTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction: accept, wait for valid, optional backpressure with a stray
    // start pulse, then the handshake. Returns the cycle stamp of the accepting edge.
    task automatic run_op(input string tag, input logic [OP_LEN-1:0] a, input logic [OP_LEN-1:0] b,
                          input int hold, input bit pulse, output int accept_cyc);
        longint unsigned exp;
        int lat;
        exp = longint'(a) * longint'(b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        ready_i = (hold == 0);
        tick();
        accept_cyc = cycle;
        start_i = 1'b0;
        a_i = OP_LEN'($urandom);
        b_i = OP_LEN'($urandom);
        check({tag, "_busy_after_accept"}, 64'(busy_o), 1);
        lat = 1;
        tick();
        while (!valid_o && lat < TIMEOUT) begin
            lat++;
            tick();
        end
        check({tag, "_latency"}, 64'(lat), 64'(LATENCY));
        check({tag, "_result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                start_i = 1'b1;
                a_i = OP_LEN'($urandom);
                b_i = OP_LEN'($urandom);
            end
            tick();
            start_i = 1'b0;
            check({tag, "_hold_valid"}, 64'(valid_o), 1);
            check({tag, "_hold_result"}, result_o, exp);
        end
        ready_i = 1'b1;
        tick();
        check({tag, "_valid_after_hs"}, 64'(valid_o), 0);
        check({tag, "_busy_after_hs"}, 64'(busy_o), 0);
        check({tag, "_result_retained"}, result_o, exp);
    endtask

    initial begin
        int acc1;
        int acc2;
        int seen_valid;

        // Reset state
        rst_i = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(busy_o), 0);
        check("rst_valid", 64'(valid_o), 0);
        check("rst_result", result_o, 0);
        rst_i = 1'b0;
        tick();

        // Directed corner cases
        run_op("one_x_one", 23'd1, 23'd1, 0, 1'b0, acc1);
        run_op("qm1_sq", 23'd8380416, 23'd8380416, 0, 1'b0, acc1);
        check("qm1_sq_const", result_o, 64'h3FE004000000);
        check("qm1_sq_mod_q", result_o % 64'd8380417, 1);
        run_op("zero_a", 23'd0, 23'd12345, 0, 1'b0, acc1);
        run_op("max_sq", 23'h7FFFFF, 23'h7FFFFF, 0, 1'b0, acc1);
        check("max_sq_const", result_o, 64'h3FFFFF000001);

        // Backpressure with an ignored start pulse
        run_op("backpress", 23'h2ABCDE, 23'h13579B, 5, 1'b1, acc1);

        // Reset at MUL step 10 aborts the operation
        start_i = 1'b1;
        a_i = 23'h654321;
        b_i = 23'h0FEDCB;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_i = 1'b1;
        tick();
        check("abort_busy", 64'(busy_o), 0);
        check("abort_valid", 64'(valid_o), 0);
        check("abort_result", result_o, 0);
        rst_i = 1'b0;
        ready_i = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_o) seen_valid++;
        end
        check("abort_no_valid", 64'(seen_valid), 0);
        run_op("three_x_five", 23'd3, 23'd5, 0, 1'b0, acc1);
        check("three_x_five_const", result_o, 15);

        // Back-to-back with ready tied high
        run_op("b2b_first", 23'h1234, 23'h56, 0, 1'b0, acc1);
        check("b2b_first_const", result_o, 64'h61D78);
        run_op("b2b_second", 23'h7FFFFF, 23'd2, 0, 1'b0, acc2);
        check("b2b_second_const", result_o, 64'hFFFFFE);
        check("b2b_interval", 64'(acc2 - acc1), 64'(OP_LEN + 2));

        // Randomized operands with random backpressure
        for (int n = 0; n < 10; n++) begin
            run_op("rand", OP_LEN'($urandom), OP_LEN'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), acc1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
